ifu_prefetch: RTL

//  Instruction-fetch stage directly downstream of the PC register. Takes the current PC and

---
 rtl/ifu_prefetch.sv | 103 ++++++++++
 1 files changed

// File: rtl/ifu_prefetch.sv
// Instruction prefetch stage: issues in-order fetches for pc_i and buffers {pc, inst} pairs
// for decode. On a jump the buffer is flushed and in-flight responses are counted off and dropped.
module ifu_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] INST_NOP = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jump_flag_i,
  output logic        hold_o,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Drops can accumulate across back-to-back jumps, so give the counter headroom.
  localparam int unsigned DW = CW + 3;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [AW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic [DW-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [CW-1:0] unfilled;
  logic          issue, rsp_live, do_fill, do_pop;

  assign unfilled    = alloc_cnt_q - fill_cnt_q;
  assign ibus_req_o  = ~rst & ~jump_flag_i & (alloc_cnt_q < DepthC);
  assign ibus_addr_o = pc_i;
  assign issue       = ibus_req_o & ibus_gnt_i;
  assign hold_o      = rst | (~issue & ~jump_flag_i);

  // A response is only meaningful if something is outstanding (old or new stream).
  assign rsp_live = ibus_rvalid_i & ((drop_cnt_q != '0) | (unfilled != '0));
  assign do_fill  = rsp_live & (drop_cnt_q == '0);

  assign inst_valid_o = (fill_cnt_q != '0) & ~jump_flag_i;
  assign inst_o       = inst_valid_o ? data_q[rd_ptr_q] : INST_NOP;
  assign inst_addr_o  = inst_valid_o ? addr_q[rd_ptr_q] : 32'h0;
  assign do_pop       = inst_valid_o & inst_ready_i;

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    alloc_cnt_d = alloc_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (jump_flag_i) begin
      fill_ptr_d  = alloc_ptr_q;
      rd_ptr_d    = alloc_ptr_q;
      alloc_cnt_d = '0;
      fill_cnt_d  = '0;
      drop_cnt_d  = drop_cnt_q + DW'(unfilled) - DW'(rsp_live);
    end else begin
      if (issue)   alloc_ptr_d = alloc_ptr_q + AW'(1);
      if (do_fill) fill_ptr_d  = fill_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d    = rd_ptr_q + AW'(1);
      alloc_cnt_d = alloc_cnt_q + CW'(issue) - CW'(do_pop);
      fill_cnt_d  = fill_cnt_q + CW'(do_fill) - CW'(do_pop);
      if (rsp_live && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      alloc_cnt_q <= '0;
      fill_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Slot payloads need no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (issue) addr_q[alloc_ptr_q] <= pc_i;
    if (do_fill && !jump_flag_i) data_q[fill_ptr_q] <= ibus_rdata_i;
  end

endmodule
